// File: rtl/slot_pkg.sv
// Shared types and constants for the slot reel engine.
// FSM state encoding, LED patterns and the payout multiplier helper.
package slot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPIN,
    ST_EVAL,
    ST_PAYOUT,
    ST_OVER
  } state_e;

  localparam logic [9:0] LED_OFF   = 10'h000;
  localparam logic [9:0] LED_ALL   = 10'h3FF;
  localparam logic [9:0] LED_WALK0 = 10'h001;

  // all_match implies pair, so priority order matters here
  function automatic logic [7:0] payout_mult(
    input logic       all_m,
    input logic       pair,
    input logic [7:0] m_all,
    input logic [7:0] m_pair
  );
    logic [7:0] m;
    m = '0;
    priority case (1'b1)
      all_m:   m = m_all;
      pair:    m = m_pair;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/slot_reel.sv
// One animated reel: advances on ticks while running,
// then loads its final symbol on its own stop tick.
module slot_reel #(
  parameter int SYMBOL_W = 3,
  parameter int TK_W     = 6,
  parameter int STOP_AT  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                tick_i,
  input  logic [TK_W-1:0]     tick_num_i,
  input  logic [SYMBOL_W-1:0] seed_i,
  output logic [SYMBOL_W-1:0] sym_o,
  output logic                stopped_o
);

  logic [SYMBOL_W-1:0] sym_q, sym_d;
  logic                run_q, run_d;

  always_comb begin
    sym_d = sym_q;
    run_d = run_q;
    if (start_i) begin
      run_d = 1'b1;
    end else if (run_q && tick_i) begin
      if (tick_num_i == TK_W'(STOP_AT)) begin
        run_d = 1'b0;
        sym_d = seed_i;
      end else begin
        sym_d = sym_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_q <= '0;
      run_q <= 1'b0;
    end else begin
      sym_q <= sym_d;
      run_q <= run_d;
    end
  end

  assign sym_o     = sym_q;
  assign stopped_o = ~run_q;

endmodule

// File: rtl/slot_reel_engine.sv
// N-reel slot engine: bet, staggered reel stops, scoring, payout.
// Optional CHEAT_MODE_EN forces every reel to the top symbol.
module slot_reel_engine
  import slot_pkg::*;
#(
  parameter int N_REELS       = 3,
  parameter int SYMBOL_W      = 3,
  parameter int RNG_W         = 16,
  parameter int CREDIT_W      = 10,
  parameter int START_CREDITS = 10,
  parameter int MAX_CREDITS   = 999,
  parameter int BET_W         = 3,
  parameter int TICK_DIV      = 2500000,
  parameter int SPIN_TICKS    = 20,
  parameter int STAGGER_TICKS = 8,
  parameter int MULT_ALL      = 10,
  parameter int MULT_PAIR     = 2,
  parameter int FLASH_TICKS   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         btn_spin,
  input  logic                         cheat_mode,
  input  logic [BET_W-1:0]             sw_bet,
  input  logic [RNG_W-1:0]             random_seed,
  output logic [N_REELS*SYMBOL_W-1:0]  symbols,
  output logic [CREDIT_W-1:0]          current_credits,
  output logic [BET_W:0]               current_bet,
  output logic                         busy,
  output logic                         win,
  output logic [9:0]                   leds
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_STOP = SPIN_TICKS + (N_REELS - 1) * STAGGER_TICKS;
  localparam int TK_W = $clog2(MAX_STOP + 1);
  localparam int FL_W = $clog2(FLASH_TICKS + 1);
  localparam int PW   = CREDIT_W + 8;

  state_e               state_q, state_d;
  logic                 btn_q, edge_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [TK_W-1:0]      tcnt_q, tcnt_d;
  logic [CREDIT_W-1:0]  credits_q, credits_d;
  logic [BET_W-1:0]     bet_q, bet_d;
  logic [PW-1:0]        payout_q, payout_d;
  logic [9:0]           walk_q, walk_d;
  logic [FL_W-1:0]      flash_q, flash_d;
  logic                 flash_on_q, flash_on_d;

  logic                 tick, tick_spin, spin_go, bet_ok;
  logic [TK_W-1:0]      tick_num;
  logic [SYMBOL_W-1:0]  sym [N_REELS];
  logic [N_REELS-1:0]   stopped;
  logic                 all_m, pair;
  logic [PW-1:0]        sum;
  logic [CREDIT_W-1:0]  new_cred;
  logic                 unused_in;

  assign tick      = (div_q == DIV_W'(TICK_DIV - 1));
  assign tick_spin = tick && (state_q == ST_SPIN);
  assign tick_num  = tcnt_q + 1'b1;
  assign unused_in = ^{1'b0, random_seed, cheat_mode};

`ifdef CHEAT_MODE_EN
  logic cheat_q, cheat_eff, r0_stop;
  assign r0_stop   = tick_spin && (tick_num == TK_W'(SPIN_TICKS));
  assign cheat_eff = r0_stop ? cheat_mode : cheat_q;

  always_ff @(posedge clk) begin
    if (!rst_n)       cheat_q <= 1'b0;
    else if (r0_stop) cheat_q <= cheat_mode;
  end
`endif

  for (genvar i = 0; i < N_REELS; i++) begin : g_reel
    logic [SYMBOL_W-1:0] seed_s;
`ifdef CHEAT_MODE_EN
    assign seed_s = cheat_eff ? '1
                  : random_seed[i*SYMBOL_W +: SYMBOL_W];
`else
    assign seed_s = random_seed[i*SYMBOL_W +: SYMBOL_W];
`endif
    slot_reel #(
      .SYMBOL_W (SYMBOL_W),
      .TK_W     (TK_W),
      .STOP_AT  (SPIN_TICKS + i * STAGGER_TICKS)
    ) u_reel (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (spin_go),
      .tick_i     (tick_spin),
      .tick_num_i (tick_num),
      .seed_i     (seed_s),
      .sym_o      (sym[i]),
      .stopped_o  (stopped[i])
    );
    assign symbols[i*SYMBOL_W +: SYMBOL_W] = sym[i];
  end

  always_comb begin
    all_m = 1'b1;
    pair  = 1'b0;
    for (int i = 1; i < N_REELS; i++)
      if (sym[i] != sym[0]) all_m = 1'b0;
    for (int i = 0; i < N_REELS; i++)
      for (int j = i + 1; j < N_REELS; j++)
        if (sym[i] == sym[j]) pair = 1'b1;
  end

  assign sum = PW'(credits_q) + payout_q;
  assign new_cred = (sum > PW'(MAX_CREDITS))
                  ? CREDIT_W'(MAX_CREDITS)
                  : sum[CREDIT_W-1:0];
  assign bet_ok = (sw_bet != '0)
               && (CREDIT_W'(sw_bet) <= credits_q);

  always_comb begin
    state_d    = state_q;
    credits_d  = credits_q;
    bet_d      = bet_q;
    payout_d   = payout_q;
    spin_go    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (edge_q && bet_ok) begin
          spin_go   = 1'b1;
          state_d   = ST_SPIN;
          bet_d     = sw_bet;
          credits_d = credits_q - CREDIT_W'(sw_bet);
        end
      end
      ST_SPIN: begin
        if (&stopped) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        payout_d = PW'(bet_q) * PW'(payout_mult(all_m, pair,
                     8'(MULT_ALL), 8'(MULT_PAIR)));
        state_d  = ST_PAYOUT;
      end
      ST_PAYOUT: begin
        credits_d = new_cred;
        state_d   = (new_cred == '0) ? ST_OVER : ST_IDLE;
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_IDLE;
    endcase
  end

  // divider free-runs so the post-win flash keeps its rhythm in IDLE
  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    tcnt_d     = tcnt_q;
    walk_d     = walk_q;
    flash_d    = flash_q;
    flash_on_d = flash_on_q;
    if (spin_go) begin
      div_d   = '0;
      tcnt_d  = '0;
      walk_d  = LED_WALK0;
      flash_d = '0;
    end else if (tick_spin) begin
      tcnt_d = tick_num;
      walk_d = {walk_q[8:0], walk_q[9]};
    end
    if (state_q == ST_PAYOUT && payout_q != '0) begin
      flash_d    = FL_W'(FLASH_TICKS);
      flash_on_d = 1'b1;
    end else if (state_q == ST_IDLE && tick && flash_q != '0) begin
      flash_d    = flash_q - 1'b1;
      flash_on_d = ~flash_on_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      btn_q      <= 1'b0;
      edge_q     <= 1'b0;
      div_q      <= '0;
      tcnt_q     <= '0;
      credits_q  <= CREDIT_W'(START_CREDITS);
      bet_q      <= '0;
      payout_q   <= '0;
      walk_q     <= LED_OFF;
      flash_q    <= '0;
      flash_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_spin;
      edge_q     <= btn_spin & ~btn_q;
      div_q      <= div_d;
      tcnt_q     <= tcnt_d;
      credits_q  <= credits_d;
      bet_q      <= bet_d;
      payout_q   <= payout_d;
      walk_q     <= walk_d;
      flash_q    <= flash_d;
      flash_on_q <= flash_on_d;
    end
  end

  always_comb begin
    leds = LED_OFF;
    unique case (state_q)
      ST_IDLE: begin
        if (flash_q != '0) leds = {10{flash_on_q}};
        else               leds = 10'(bet_q);
      end
      ST_OVER: leds = LED_ALL;
      default: leds = walk_q;
    endcase
  end

  assign current_credits = credits_q;
  assign current_bet     = {1'b0, bet_q};
  assign busy = (state_q != ST_IDLE) && (state_q != ST_OVER);
  assign win  = (state_q == ST_PAYOUT) && (payout_q != '0);

endmodule

// File: tb/tb_slot_reel_engine.sv
// Directed bench for slot_reel_engine with a short tick divider.
// Expected values are hand-derived from the reel/payout rules.
module tb_slot_reel_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_spin = 1'b0;
  logic        cheat_mode = 1'b0;
  logic [2:0]  sw_bet = '0;
  logic [15:0] random_seed = '0;
  logic [8:0]  symbols;
  logic [9:0]  current_credits;
  logic [3:0]  current_bet;
  logic        busy, win;
  logic [9:0]  leds;

  int n_vec = 0;
  int n_bad = 0;
  int win_cnt = 0;
  int busy_rise = 0;
  logic busy_d = 1'b0;

  localparam logic [15:0] LOSE = 16'h00D1;
  localparam logic [15:0] JACK = 16'h0FFF;

  slot_reel_engine #(
    .N_REELS       (3),
    .SYMBOL_W      (3),
    .RNG_W         (16),
    .CREDIT_W      (10),
    .START_CREDITS (10),
    .MAX_CREDITS   (999),
    .BET_W         (3),
    .TICK_DIV      (4),
    .SPIN_TICKS    (8),
    .STAGGER_TICKS (2),
    .MULT_ALL      (10),
    .MULT_PAIR     (2),
    .FLASH_TICKS   (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .btn_spin        (btn_spin),
    .cheat_mode      (cheat_mode),
    .sw_bet          (sw_bet),
    .random_seed     (random_seed),
    .symbols         (symbols),
    .current_credits (current_credits),
    .current_bet     (current_bet),
    .busy            (busy),
    .win             (win),
    .leds            (leds)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (win) win_cnt++;
    if (busy && !busy_d) busy_rise++;
    busy_d = busy;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    btn_spin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press;
    @(negedge clk) btn_spin = 1'b1;
    @(negedge clk) btn_spin = 1'b0;
  endtask

  task automatic spin(input logic [2:0] bet, input logic [15:0] seed);
    int n;
    sw_bet = bet;
    random_seed = seed;
    press();
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("start_timeout", 32'(busy), 1);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("end_timeout", 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, c;

    // 1: reset state and a full spin timeline
    do_reset();
    chk("rst_cred", 32'(current_credits), 10);
    chk("rst_bet", 32'(current_bet), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_win", 32'(win), 0);
    chk("rst_leds", 32'(leds), 0);
    chk("rst_sym", 32'(symbols), 0);

    sw_bet = 3'd3;
    random_seed = 16'h00F5;
    @(negedge clk) btn_spin = 1'b1;
    cyc(1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_cred", 32'(current_credits), 10);
    btn_spin = 1'b0;
    cyc(1);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_cred", 32'(current_credits), 7);
    chk("t2_bet", 32'(current_bet), 3);
    chk("t2_walk", 32'(leds), 10'h001);
    cyc(32);
    chk("tick8_sym", 32'(symbols), 9'h005);
    chk("tick8_led", 32'(leds), 10'h100);
    cyc(8);
    chk("tick10_sym", 32'(symbols), 9'h0B5);
    chk("tick10_led", 32'(leds), 10'h001);
    cyc(8);
    chk("tick12_sym", 32'(symbols), 9'h0F5);
    chk("tick12_busy", 32'(busy), 1);
    cyc(2);
    chk("payout_busy", 32'(busy), 1);
    chk("payout_win", 32'(win), 0);
    cyc(1);
    chk("done_busy", 32'(busy), 0);
    chk("done_cred", 32'(current_credits), 7);
    chk("done_leds", 32'(leds), 10'h003);

    // 2: all-match jackpot
    do_reset();
    w0 = win_cnt;
    spin(3'd3, JACK);
    chk("jack_sym", 32'(symbols), 9'h1FF);
    chk("jack_cred", 32'(current_credits), 37);
    chk("jack_win", 32'(win_cnt - w0), 1);
    chk("flash_on", 32'(leds), 10'h3FF);
    cyc(80);
    chk("flash_end", 32'(leds), 10'h003);

    // 3: pair and loss
    do_reset();
    w0 = win_cnt;
    spin(3'd2, 16'h0061);
    chk("pair_cred", 32'(current_credits), 12);
    chk("pair_win", 32'(win_cnt - w0), 1);
    do_reset();
    w0 = win_cnt;
    spin(3'd2, LOSE);
    chk("lose_cred", 32'(current_credits), 8);
    chk("lose_win", 32'(win_cnt - w0), 0);

    // 4: invalid bets and a held button
    do_reset();
    sw_bet = 3'd0;
    press();
    cyc(5);
    chk("bet0_busy", 32'(busy), 0);
    chk("bet0_cred", 32'(current_credits), 10);
    spin(3'd6, LOSE);
    chk("to4_cred", 32'(current_credits), 4);
    sw_bet = 3'd5;
    press();
    cyc(5);
    chk("over_busy", 32'(busy), 0);
    chk("over_cred", 32'(current_credits), 4);
    r0 = busy_rise;
    sw_bet = 3'd1;
    random_seed = LOSE;
    @(negedge clk) btn_spin = 1'b1;
    cyc(1000);
    btn_spin = 1'b0;
    cyc(5);
    chk("held_spins", 32'(busy_rise - r0), 1);
    chk("held_cred", 32'(current_credits), 3);

    // 5: game over, recovery, saturation
    do_reset();
    spin(3'd7, LOSE);
    spin(3'd1, LOSE);
    chk("go_pre", 32'(current_credits), 2);
    spin(3'd2, LOSE);
    chk("go_cred", 32'(current_credits), 0);
    chk("go_leds", 32'(leds), 10'h3FF);
    chk("go_busy", 32'(busy), 0);
    sw_bet = 3'd1;
    press();
    cyc(5);
    chk("go_stuck", 32'(busy), 0);
    chk("go_leds2", 32'(leds), 10'h3FF);
    do_reset();
    chk("go_rst_cred", 32'(current_credits), 10);
    chk("go_rst_leds", 32'(leds), 0);
    c = 10;
    for (int k = 0; k < 16; k++) begin
      spin(3'd7, JACK);
      c = (c + 63 > 999) ? 999 : c + 63;
      chk("sat", 32'(current_credits), 32'(c));
    end
    chk("sat_final", 32'(current_credits), 999);

    // 6: reset mid-spin
    do_reset();
    sw_bet = 3'd3;
    random_seed = JACK;
    press();
    cyc(20);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_sym", 32'(symbols), 0);
    chk("mid_cred", 32'(current_credits), 10);
    chk("mid_busy0", 32'(busy), 0);
    chk("mid_bet", 32'(current_bet), 0);
    rst_n = 1'b1;

`ifdef CHEAT_MODE_EN
    do_reset();
    cheat_mode = 1'b1;
    spin(3'd1, LOSE);
    chk("cheat_sym", 32'(symbols), 9'h1FF);
    chk("cheat_cred", 32'(current_credits), 19);
    cheat_mode = 1'b0;
`endif

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
